// File: rtl/lfsr_prng.sv
// lfsr_prng: parametrised Fibonacci LFSR random word source with valid/ready output and reseed
module lfsr_prng #(
    parameter int               WIDTH        = 32,
    parameter int               OUT_W        = 8,
    parameter logic [WIDTH-1:0] DEFAULT_SEED = WIDTH'(64'hDEAD_BEEF),
    parameter int               CNT_W        = 16
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             seed_load_i,
    input  logic [WIDTH-1:0] seed_i,
    output logic [OUT_W-1:0] d_o,
    output logic             valid_o,
    input  logic             ready_i,
    output logic             zero_fix_o,
    output logic [CNT_W-1:0] count_o
);
    localparam logic [63:0] TAPS_ALL =
        (WIDTH == 8)  ? 64'h0000_0000_0000_00B8 :
        (WIDTH == 16) ? 64'h0000_0000_0000_D008 :
        (WIDTH == 24) ? 64'h0000_0000_00E1_0000 :
        (WIDTH == 32) ? 64'h0000_0000_8020_0003 :
                        64'hD800_0000_0000_0000;
    localparam logic [WIDTH-1:0] TAPS = TAPS_ALL[WIDTH-1:0];

    generate
        if (WIDTH != 8 && WIDTH != 16 && WIDTH != 24 && WIDTH != 32 && WIDTH != 64) begin : g_bad_width
            $error("lfsr_prng: WIDTH must be 8, 16, 24, 32 or 64");
        end
        if (OUT_W < 1 || OUT_W > WIDTH) begin : g_bad_out_w
            $error("lfsr_prng: OUT_W must be in 1..WIDTH");
        end
        if (DEFAULT_SEED == '0) begin : g_bad_seed
            $error("lfsr_prng: DEFAULT_SEED must be nonzero");
        end
    endgenerate

    typedef enum logic {FILL, HOLD} state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] s_q, s_d, s_adv;
    logic [OUT_W-1:0] word, d_d;
    logic [CNT_W-1:0] cnt_d;
    logic             fb, zfix_d, hs, seed_zero;

    assign valid_o   = state_q == HOLD;
    assign hs        = valid_o && ready_i;
    assign seed_zero = seed_i == '0;

    // Unroll OUT_W steps: word bit i is the feedback of step i, s_adv is the state after all of them
    always_comb begin
        fb    = 1'b0;
        s_adv = s_q;
        word  = '0;
        for (int i = 0; i < OUT_W; i++) begin
            fb      = ^(s_adv & TAPS);
            word[i] = fb;
            s_adv   = {s_adv[WIDTH-2:0], fb};
        end
    end

    // Next state: seed load beats lock-up recovery, which beats word generation
    always_comb begin
        state_d = state_q;
        s_d     = s_q;
        d_d     = d_o;
        zfix_d  = 1'b0;
        cnt_d   = count_o + CNT_W'(hs);
        if (seed_load_i) begin
            s_d     = seed_zero ? DEFAULT_SEED : seed_i;
            zfix_d  = seed_zero;
            state_d = FILL;
        end else if (s_q == '0) begin
            s_d     = DEFAULT_SEED;
            zfix_d  = 1'b1;
            state_d = FILL;
        end else if (state_q == FILL || ready_i) begin
            s_d     = s_adv;
            d_d     = word;
            state_d = HOLD;
        end
    end

    // Registers for FSM, LFSR state, output word, zero-fix pulse and handshake counter
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q    <= FILL;
            s_q        <= DEFAULT_SEED;
            d_o        <= '0;
            zero_fix_o <= 1'b0;
            count_o    <= '0;
        end else begin
            state_q    <= state_d;
            s_q        <= s_d;
            d_o        <= d_d;
            zero_fix_o <= zfix_d;
            count_o    <= cnt_d;
        end
    end
endmodule
